// File: rtl/lane_fill_scheduler.sv
`default_nettype none
// ============================================================================
// lane_fill_scheduler : one-hot lane strobe sequencer for a 1-to-N 66b
//                       converter, with periodic alignment-marker word slots.
// Optional build macro: LANE_FILL_DROP_COUNT_EN (saturating refused-block count)
// Revision: 1.0
// ============================================================================
module lane_fill_scheduler #(
    parameter int N_LANES   = 20,
    parameter int NB_IDX    = 5,
    parameter int AM_PERIOD = 16383,
    parameter int NB_WCOUNT = 14,
    parameter int NB_DROP   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [N_LANES-1:0]   o_lane_sel,
    output logic [NB_IDX-1:0]    o_lane_idx,
    output logic [N_LANES-1:0]   o_lane_we,
    output logic [N_LANES-1:0]   o_am_we,
    output logic                 o_word_valid,
    output logic                 o_word_is_am,
    output logic [NB_WCOUNT-1:0] o_word_count
`ifdef LANE_FILL_DROP_COUNT_EN
    ,
    output logic [NB_DROP-1:0]   o_drop_count
`endif
);

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        AM_SLOT = 1'b1
    } state_t;

    localparam logic [N_LANES-1:0]   LANE0_SEL = {1'b1, {(N_LANES-1){1'b0}}};
    localparam logic [NB_IDX-1:0]    LAST_IDX  = NB_IDX'(N_LANES - 1);
    localparam bit                   AM_EN     = (AM_PERIOD != 0);
    localparam logic [NB_WCOUNT-1:0] AM_LAST   = AM_EN ? NB_WCOUNT'(AM_PERIOD - 1) : '0;

    generate
        if (((2 ** NB_IDX) < N_LANES) || (AM_PERIOD < 0) ||
            (AM_PERIOD > (2 ** NB_WCOUNT)) || (NB_DROP < 1)) begin : g_bad_params
            $error("lane_fill_scheduler: inconsistent parameter set");
        end
    endgenerate

    state_t state;
    logic   accept;
    logic   am_step;
    logic   at_last_lane;

    assign o_ready      = i_enable && (state == FILL);
    assign accept       = i_valid && o_ready;
    assign am_step      = i_enable && (state == AM_SLOT);
    assign at_last_lane = (o_lane_idx == LAST_IDX);
    assign o_lane_we    = accept  ? o_lane_sel : '0;
    assign o_am_we      = am_step ? o_lane_sel : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= FILL;
            o_lane_sel   <= LANE0_SEL;
            o_lane_idx   <= '0;
            o_word_valid <= 1'b0;
            o_word_is_am <= 1'b0;
            o_word_count <= '0;
        end else begin
            // The word pulse is self-clearing, even while disabled.
            o_word_valid <= 1'b0;
            o_word_is_am <= 1'b0;
            if (accept || am_step) begin
                if (at_last_lane) begin
                    o_lane_sel   <= LANE0_SEL;
                    o_lane_idx   <= '0;
                    o_word_valid <= 1'b1;
                    if (state == AM_SLOT) begin
                        o_word_is_am <= 1'b1;
                        state        <= FILL;
                    end else if (AM_EN && (o_word_count == AM_LAST)) begin
                        o_word_count <= '0;
                        state        <= AM_SLOT;
                    end else begin
                        o_word_count <= o_word_count + NB_WCOUNT'(1);
                    end
                end else begin
                    o_lane_sel <= o_lane_sel >> 1;
                    o_lane_idx <= o_lane_idx + NB_IDX'(1);
                end
            end
        end
    end

`ifdef LANE_FILL_DROP_COUNT_EN
    // Any offered block that is refused counts, including while disabled.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_drop_count <= '0;
        end else if (i_valid && !o_ready && (o_drop_count != '1)) begin
            o_drop_count <= o_drop_count + NB_DROP'(1);
        end
    end
`else
    // Without drop tracking a refused block leaves no trace at all.
`endif

endmodule
`default_nettype wire
